bellek_erisim: RTL and testbench

Memory-access stage directly downstream of the ALU (AMB). It consumes the registered ALU result: the effective address for load/store ops, or the plain result otherwise. It drives a single-port data-memory request/ready handshake and forms byte-lane masks for stores. For loads it aligns and sign/zero-extends the returned data, then presents a registered result to write-back. While a memory transaction is outstanding it stalls the upstream pipeline.

---
 rtl/bellek_erisim.sv | 133 +++++++++++++
 tb/tb_bellek_erisim.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bellek_erisim.sv
// bellek_erisim: memory-access stage; drives a data-memory handshake, forms store lanes,
// aligns/extends load data and registers the write-back result.
module bellek_erisim #(
  parameter int unsigned ZAMAN_ASIMI_CEVRIM = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        amb_gecerli_i,
  input  logic [31:0] amb_sonuc_i,
  input  logic [31:0] yazmac_degeri2_i,
  input  logic        bellek_oku_i,
  input  logic        bellek_yaz_i,
  input  logic [1:0]  bellek_boyut_i,
  input  logic        isaretsiz_i,
  input  logic [4:0]  hedef_yazmac_i,
  input  logic        yaz_aktif_i,
  output logic        veri_istek_o,
  output logic        veri_yaz_aktif_o,
  output logic [31:0] veri_adres_o,
  output logic [31:0] veri_yaz_o,
  output logic [3:0]  veri_maske_o,
  input  logic        veri_hazir_i,
  input  logic [31:0] veri_oku_i,
  output logic        durdur_o,
  output logic        gy_gecerli_o,
  output logic        gy_yaz_aktif_o,
  output logic [4:0]  gy_hedef_o,
  output logic [31:0] gy_sonuc_o,
  output logic        hizalama_hatasi_o,
  output logic        erisim_hatasi_o
);
  typedef enum logic {BOSTA, BEKLE} durum_t;
  localparam int unsigned SW = (ZAMAN_ASIMI_CEVRIM > 1) ? $clog2(ZAMAN_ASIMI_CEVRIM) : 1;
  localparam logic [SW-1:0] SON = SW'((ZAMAN_ASIMI_CEVRIM == 0) ? 0 : ZAMAN_ASIMI_CEVRIM - 1);
  durum_t      durum_q;
  logic [SW-1:0] sayac_q;
  logic [31:0] adres_q, yaz_veri_q, gy_sonuc_q;
  logic [3:0]  maske_q;
  logic [1:0]  boyut_q;
  logic [4:0]  hedef_q, gy_hedef_q;
  logic        yazma_q, isaretsiz_q, rd_yaz_q;
  logic        gy_gecerli_q, gy_yaz_aktif_q, hizalama_q, erisim_q;
  logic        bellek_op, hizasiz;
  logic [31:0] yaz_veri_d, yukle_d;
  logic [3:0]  maske_d;
  logic [7:0]  bayt;
  logic [15:0] yarim;
  assign bellek_op = bellek_oku_i | bellek_yaz_i;
  assign hizasiz   = (bellek_boyut_i == 2'd1) ? amb_sonuc_i[0] :
                     bellek_boyut_i[1] ? |amb_sonuc_i[1:0] : 1'b0;
  assign durdur_o  = (durum_q == BEKLE) |
                     (amb_gecerli_i & bellek_op & ~hizasiz);
  always_comb begin
    yaz_veri_d = bellek_oku_i ? 32'h0 :
                 (bellek_boyut_i == 2'd0) ? {4{yazmac_degeri2_i[7:0]}} :
                 (bellek_boyut_i == 2'd1) ? {2{yazmac_degeri2_i[15:0]}} : yazmac_degeri2_i;
    maske_d    = bellek_oku_i ? 4'hF :
                 (bellek_boyut_i == 2'd0) ? 4'b0001 << amb_sonuc_i[1:0] :
                 (bellek_boyut_i == 2'd1) ? 4'b0011 << {amb_sonuc_i[1], 1'b0} : 4'hF;
    bayt       = veri_oku_i[{adres_q[1:0], 3'b000} +: 8];
    yarim      = veri_oku_i[{adres_q[1], 4'b0000} +: 16];
    yukle_d    = (boyut_q == 2'd0) ? {{24{~isaretsiz_q & bayt[7]}}, bayt} :
                 (boyut_q == 2'd1) ? {{16{~isaretsiz_q & yarim[15]}}, yarim} : veri_oku_i;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q        <= BOSTA;
      sayac_q        <= '0;
      adres_q        <= '0;
      yaz_veri_q     <= '0;
      maske_q        <= '0;
      boyut_q        <= '0;
      hedef_q        <= '0;
      yazma_q        <= 1'b0;
      isaretsiz_q    <= 1'b0;
      rd_yaz_q       <= 1'b0;
      gy_gecerli_q   <= 1'b0;
      gy_yaz_aktif_q <= 1'b0;
      gy_hedef_q     <= '0;
      gy_sonuc_q     <= '0;
      hizalama_q     <= 1'b0;
      erisim_q       <= 1'b0;
    end else begin
      gy_gecerli_q <= 1'b0;
      hizalama_q   <= 1'b0;
      erisim_q     <= 1'b0;
      if (durum_q == BOSTA) begin
        if (amb_gecerli_i && !bellek_op) begin
          gy_gecerli_q   <= 1'b1;
          gy_sonuc_q     <= amb_sonuc_i;
          gy_hedef_q     <= hedef_yazmac_i;
          gy_yaz_aktif_q <= yaz_aktif_i;
        end else if (amb_gecerli_i && hizasiz) begin
          hizalama_q <= 1'b1;
        end else if (amb_gecerli_i) begin
          durum_q     <= BEKLE;
          sayac_q     <= '0;
          adres_q     <= amb_sonuc_i;
          yaz_veri_q  <= yaz_veri_d;
          maske_q     <= maske_d;
          boyut_q     <= bellek_boyut_i;
          isaretsiz_q <= isaretsiz_i;
          hedef_q     <= hedef_yazmac_i;
          rd_yaz_q    <= yaz_aktif_i;
          yazma_q     <= ~bellek_oku_i;
        end
      end else if (veri_hazir_i) begin
        // completion wins over a timeout reached in the same cycle
        durum_q        <= BOSTA;
        gy_gecerli_q   <= 1'b1;
        gy_hedef_q     <= hedef_q;
        gy_yaz_aktif_q <= ~yazma_q & rd_yaz_q;
        gy_sonuc_q     <= yazma_q ? 32'h0 : yukle_d;
      end else if (ZAMAN_ASIMI_CEVRIM != 0 && sayac_q == SON) begin
        durum_q  <= BOSTA;
        erisim_q <= 1'b1;
      end else begin
        sayac_q <= sayac_q + 1'b1;
      end
    end
  end
  assign veri_istek_o      = (durum_q == BEKLE);
  assign veri_yaz_aktif_o  = yazma_q;
  assign veri_adres_o      = {adres_q[31:2], 2'b00};
  assign veri_yaz_o        = yaz_veri_q;
  assign veri_maske_o      = maske_q;
  assign gy_gecerli_o      = gy_gecerli_q;
  assign gy_yaz_aktif_o    = gy_yaz_aktif_q;
  assign gy_hedef_o        = gy_hedef_q;
  assign gy_sonuc_o        = gy_sonuc_q;
  assign hizalama_hatasi_o = hizalama_q;
  assign erisim_hatasi_o   = erisim_q;
endmodule

// File: tb/tb_bellek_erisim.sv
// tb_bellek_erisim: directed tests for bellek_erisim with a short (8-cycle) timeout.
module tb_bellek_erisim;
  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        amb_gecerli_i = 0, bellek_oku_i = 0, bellek_yaz_i = 0, isaretsiz_i = 0, yaz_aktif_i = 0;
  logic [31:0] amb_sonuc_i = 0, yazmac_degeri2_i = 0, veri_oku_i = 0;
  logic [1:0]  bellek_boyut_i = 0;
  logic [4:0]  hedef_yazmac_i = 0;
  logic        veri_hazir_i = 0;
  logic        veri_istek_o, veri_yaz_aktif_o, durdur_o, gy_gecerli_o, gy_yaz_aktif_o;
  logic        hizalama_hatasi_o, erisim_hatasi_o;
  logic [31:0] veri_adres_o, veri_yaz_o, gy_sonuc_o;
  logic [3:0]  veri_maske_o;
  logic [4:0]  gy_hedef_o;
  int checks = 0, errors = 0;

  bellek_erisim #(.ZAMAN_ASIMI_CEVRIM(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .amb_gecerli_i(amb_gecerli_i), .amb_sonuc_i(amb_sonuc_i),
    .yazmac_degeri2_i(yazmac_degeri2_i), .bellek_oku_i(bellek_oku_i), .bellek_yaz_i(bellek_yaz_i),
    .bellek_boyut_i(bellek_boyut_i), .isaretsiz_i(isaretsiz_i), .hedef_yazmac_i(hedef_yazmac_i),
    .yaz_aktif_i(yaz_aktif_i), .veri_istek_o(veri_istek_o), .veri_yaz_aktif_o(veri_yaz_aktif_o),
    .veri_adres_o(veri_adres_o), .veri_yaz_o(veri_yaz_o), .veri_maske_o(veri_maske_o),
    .veri_hazir_i(veri_hazir_i), .veri_oku_i(veri_oku_i), .durdur_o(durdur_o),
    .gy_gecerli_o(gy_gecerli_o), .gy_yaz_aktif_o(gy_yaz_aktif_o), .gy_hedef_o(gy_hedef_o),
    .gy_sonuc_o(gy_sonuc_o), .hizalama_hatasi_o(hizalama_hatasi_o), .erisim_hatasi_o(erisim_hatasi_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic bosalt();
    amb_gecerli_i = 0; bellek_oku_i = 0; bellek_yaz_i = 0; veri_hazir_i = 0;
  endtask

  task automatic surmek(input logic oku, input logic yaz, input logic [31:0] adr, input logic [1:0] bt,
                        input logic ie, input logic [31:0] d, input logic [4:0] rd);
    amb_gecerli_i = 1; bellek_oku_i = oku; bellek_yaz_i = yaz; amb_sonuc_i = adr;
    bellek_boyut_i = bt; isaretsiz_i = ie; yazmac_degeri2_i = d; hedef_yazmac_i = rd; yaz_aktif_i = 1;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++; if (veri_istek_o !== 1'b0) begin errors++; $display("FAIL reset_istek: got %b expected 0", veri_istek_o); end
    checks++; if (durdur_o !== 1'b0) begin errors++; $display("FAIL reset_durdur: got %b expected 0", durdur_o); end
    checks++; if (gy_gecerli_o !== 1'b0) begin errors++; $display("FAIL reset_gy_gecerli: got %b expected 0", gy_gecerli_o); end
    checks++; if (veri_maske_o !== 4'h0) begin errors++; $display("FAIL reset_maske: got %h expected 0", veri_maske_o); end
    checks++; if (gy_sonuc_o !== 32'h0) begin errors++; $display("FAIL reset_gy_sonuc: got %h expected 0", gy_sonuc_o); end
    checks++; if ({hizalama_hatasi_o, erisim_hatasi_o} !== 2'b00) begin errors++; $display("FAIL reset_hatalar: got %b expected 00", {hizalama_hatasi_o, erisim_hatasi_o}); end
    rst_i = 1;
    @(negedge clk_i);
  endtask

  task automatic test_alu(input logic [31:0] s, input logic [4:0] rd);
    surmek(0, 0, s, 2'd2, 0, 0, rd);
    #1;
    checks++; if (durdur_o !== 1'b0) begin errors++; $display("FAIL alu_durdur: got %b expected 0", durdur_o); end
    @(negedge clk_i); bosalt();
    checks++; if (gy_gecerli_o !== 1'b1) begin errors++; $display("FAIL alu_gy_gecerli: got %b expected 1", gy_gecerli_o); end
    checks++; if (gy_sonuc_o !== s) begin errors++; $display("FAIL alu_gy_sonuc: got %h expected %h", gy_sonuc_o, s); end
    checks++; if (gy_hedef_o !== rd) begin errors++; $display("FAIL alu_gy_hedef: got %0d expected %0d", gy_hedef_o, rd); end
    checks++; if (gy_yaz_aktif_o !== 1'b1) begin errors++; $display("FAIL alu_gy_yaz_aktif: got %b expected 1", gy_yaz_aktif_o); end
    @(negedge clk_i);
    checks++; if (gy_gecerli_o !== 1'b0) begin errors++; $display("FAIL alu_pulse: got %b expected 0", gy_gecerli_o); end
  endtask

  task automatic test_load(input logic [31:0] adr, input logic [1:0] bt, input logic ie,
                           input logic [31:0] rdata, input logic [31:0] beklenen, input int k);
    int st = 0;
    surmek(1, 0, adr, bt, ie, 32'h0, 5'd7);
    for (int c = 0; c <= k; c++) begin
      if (c == k) begin veri_hazir_i = 1; veri_oku_i = rdata; end
      #1; st += int'(durdur_o);
      if (c == 1) begin
        checks++; if (veri_istek_o !== 1'b1) begin errors++; $display("FAIL load_istek: got %b expected 1", veri_istek_o); end
        checks++; if (veri_adres_o !== {adr[31:2], 2'b00}) begin errors++; $display("FAIL load_adres: got %h expected %h", veri_adres_o, {adr[31:2], 2'b00}); end
        checks++; if ({veri_yaz_aktif_o, veri_maske_o} !== 5'h0F) begin errors++; $display("FAIL load_maske: got %b/%h expected 0/f", veri_yaz_aktif_o, veri_maske_o); end
      end
      @(negedge clk_i);
    end
    bosalt(); #1;
    checks++; if (gy_gecerli_o !== 1'b1) begin errors++; $display("FAIL load_gy_gecerli: got %b expected 1", gy_gecerli_o); end
    checks++; if (gy_sonuc_o !== beklenen) begin errors++; $display("FAIL load_gy_sonuc: got %h expected %h", gy_sonuc_o, beklenen); end
    checks++; if ({gy_yaz_aktif_o, gy_hedef_o} !== {1'b1, 5'd7}) begin errors++; $display("FAIL load_gy_hedef: got %b/%0d expected 1/7", gy_yaz_aktif_o, gy_hedef_o); end
    checks++; if (veri_istek_o !== 1'b0) begin errors++; $display("FAIL load_istek_dus: got %b expected 0", veri_istek_o); end
    checks++; if (st != k + 1) begin errors++; $display("FAIL load_durdur_sayi: got %0d expected %0d", st, k + 1); end
    @(negedge clk_i);
  endtask

  task automatic test_store(input logic [31:0] adr, input logic [1:0] bt, input logic [31:0] d,
                            input logic [31:0] bveri, input logic [3:0] bmaske);
    surmek(0, 1, adr, bt, 0, d, 5'd9);
    @(negedge clk_i);
    checks++; if (veri_istek_o !== 1'b1 || veri_yaz_aktif_o !== 1'b1) begin errors++; $display("FAIL store_istek: got %b/%b expected 1/1", veri_istek_o, veri_yaz_aktif_o); end
    checks++; if (veri_yaz_o !== bveri) begin errors++; $display("FAIL store_veri: got %h expected %h", veri_yaz_o, bveri); end
    checks++; if (veri_maske_o !== bmaske) begin errors++; $display("FAIL store_maske: got %b expected %b", veri_maske_o, bmaske); end
    checks++; if (veri_adres_o !== {adr[31:2], 2'b00}) begin errors++; $display("FAIL store_adres: got %h expected %h", veri_adres_o, {adr[31:2], 2'b00}); end
    veri_hazir_i = 1;
    @(negedge clk_i); bosalt();
    checks++; if (gy_gecerli_o !== 1'b1 || gy_yaz_aktif_o !== 1'b0) begin errors++; $display("FAIL store_gy: got %b/%b expected 1/0", gy_gecerli_o, gy_yaz_aktif_o); end
    checks++; if (gy_sonuc_o !== 32'h0) begin errors++; $display("FAIL store_gy_sonuc: got %h expected 0", gy_sonuc_o); end
    @(negedge clk_i);
  endtask

  task automatic test_misaligned(input logic oku, input logic [31:0] adr, input logic [1:0] bt);
    surmek(oku, ~oku, adr, bt, 0, 32'h0, 5'd4);
    #1;
    checks++; if (durdur_o !== 1'b0) begin errors++; $display("FAIL hiza_durdur: got %b expected 0", durdur_o); end
    @(negedge clk_i); bosalt();
    checks++; if (hizalama_hatasi_o !== 1'b1) begin errors++; $display("FAIL hiza_pulse: got %b expected 1", hizalama_hatasi_o); end
    checks++; if (veri_istek_o !== 1'b0 || gy_gecerli_o !== 1'b0) begin errors++; $display("FAIL hiza_istek_gy: got %b/%b expected 0/0", veri_istek_o, gy_gecerli_o); end
    @(negedge clk_i);
    checks++; if (hizalama_hatasi_o !== 1'b0 || veri_istek_o !== 1'b0) begin errors++; $display("FAIL hiza_sonra: got %b/%b expected 0/0", hizalama_hatasi_o, veri_istek_o); end
  endtask

  task automatic test_timeout();
    int n = 0;
    surmek(1, 0, 32'h100, 2'd2, 0, 32'h0, 5'd6);
    @(negedge clk_i);
    for (int c = 0; c < 20 && veri_istek_o === 1'b1; c++) begin n++; @(negedge clk_i); end
    bosalt();
    checks++; if (n != 8) begin errors++; $display("FAIL zaman_asimi_sure: got %0d expected 8", n); end
    checks++; if (erisim_hatasi_o !== 1'b1) begin errors++; $display("FAIL zaman_asimi_pulse: got %b expected 1", erisim_hatasi_o); end
    checks++; if (gy_gecerli_o !== 1'b0) begin errors++; $display("FAIL zaman_asimi_gy: got %b expected 0", gy_gecerli_o); end
    #1;
    checks++; if (durdur_o !== 1'b0) begin errors++; $display("FAIL zaman_asimi_durdur: got %b expected 0", durdur_o); end
    @(negedge clk_i);
    checks++; if (erisim_hatasi_o !== 1'b0) begin errors++; $display("FAIL zaman_asimi_tek: got %b expected 0", erisim_hatasi_o); end
    test_alu(32'h0000_0055, 5'd3);
  endtask

  task automatic test_reset_mid();
    surmek(1, 0, 32'h100, 2'd2, 0, 32'h0, 5'd2);
    @(negedge clk_i); @(negedge clk_i);
    checks++; if (veri_istek_o !== 1'b1) begin errors++; $display("FAIL sifirla_once: got %b expected 1", veri_istek_o); end
    bosalt(); #2; rst_i = 0; #1;
    checks++; if (veri_istek_o !== 1'b0 || durdur_o !== 1'b0) begin errors++; $display("FAIL sifirla_hemen: got %b/%b expected 0/0", veri_istek_o, durdur_o); end
    @(negedge clk_i); rst_i = 1; veri_hazir_i = 1; veri_oku_i = 32'h1234_5678;
    @(negedge clk_i); veri_hazir_i = 0;
    checks++; if (gy_gecerli_o !== 1'b0 || veri_istek_o !== 1'b0) begin errors++; $display("FAIL sifirla_gec_hazir: got %b/%b expected 0/0", gy_gecerli_o, veri_istek_o); end
  endtask

  initial begin
    test_reset();
    test_alu(32'h0000_1234, 5'd5);
    test_load(32'h103, 2'd0, 0, 32'h80FF_FFFF, 32'hFFFF_FF80, 3);
    test_load(32'h103, 2'd0, 1, 32'h80FF_FFFF, 32'h0000_0080, 3);
    test_load(32'h102, 2'd1, 0, 32'h8001_2345, 32'hFFFF_8001, 1);
    test_load(32'h200, 2'd1, 1, 32'h8001_C345, 32'h0000_C345, 2);
    test_load(32'h104, 2'd2, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 8);
    test_store(32'h202, 2'd1, 32'hAAAA_BEEF, 32'hBEEF_BEEF, 4'b1100);
    test_store(32'h301, 2'd0, 32'h1234_5678, 32'h7878_7878, 4'b0010);
    test_store(32'h400, 2'd3, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111);
    test_misaligned(1, 32'h102, 2'd2);
    test_misaligned(0, 32'h201, 2'd1);
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
